// File: rtl/row_clear_engine_if.sv
// Handshake and grid bus between the grid register and the row-clear stage.
// The master drives start/grid_in; the slave returns the compacted grid and line counts.
interface row_clear_engine_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 3
) ();
  logic                     start;
  logic [ROWS*COLS*CW-1:0]  grid_in;
  logic                     busy;
  logic                     done;
  logic [ROWS*COLS*CW-1:0]  grid_out;
  logic [4:0]               lines_cleared;
  logic [15:0]              total_lines;

  modport master (
    output start, grid_in,
    input  busy, done, grid_out, lines_cleared, total_lines
  );

  modport slave (
    input  start, grid_in,
    output busy, done, grid_out, lines_cleared, total_lines
  );
endinterface

// File: rtl/row_clear_engine.sv
// Line-clear stage: snapshots the grid, scans rows bottom to top one per clock,
// deletes full rows by shifting everything above down, and counts cleared lines.
module row_clear_engine #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  row_clear_engine_if.slave bus
);
  localparam int RW    = $clog2(ROWS);
  localparam int ROW_W = COLS * CW;
  localparam int GW    = ROWS * ROW_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [RW-1:0]   row_r;
  logic [GW-1:0]   grid_r;
  logic [4:0]      lines_r;
  logic [15:0]     total_r;
  logic            busy_r;
  logic            done_r;

  logic [ROW_W-1:0] cur_row_s;
  logic             row_full_s;
  logic [GW-1:0]    shifted_s;
  logic             accept_s;
  logic             clear_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;

  // Row under the pointer and whether every cell in it holds a colour
  always_comb begin
    cur_row_s  = grid_r[row_r*ROW_W +: ROW_W];
    row_full_s = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      row_full_s = row_full_s & (|cur_row_s[c*CW +: CW]);
    end
  end

  // Grid with the pointed row removed: rows above drop by one, top row refills empty
  always_comb begin
    shifted_s = grid_r;
    for (int i = 0; i < ROWS; i++) begin
      if (RW'(i) > row_r) begin
        shifted_s[i*ROW_W +: ROW_W] = grid_r[i*ROW_W +: ROW_W];
      end else if (i == 0) begin
        shifted_s[i*ROW_W +: ROW_W] = {ROW_W{1'b0}};
      end else begin
        shifted_s[i*ROW_W +: ROW_W] = grid_r[(i-1)*ROW_W +: ROW_W];
      end
    end
  end

  // DONE accepts start exactly like IDLE, so back-to-back passes need no gap cycle
  assign accept_s = bus.start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign clear_s  = (state_r == S_SCAN) && row_full_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) next_state_s = S_SCAN;
        else           next_state_s = S_IDLE;
      end
      S_SCAN: begin
        if (!row_full_s && (row_r == {RW{1'b0}})) next_state_s = S_DONE;
        else                                      next_state_s = S_SCAN;
      end
      S_DONE: begin
        if (bus.start) next_state_s = S_SCAN;
        else           next_state_s = S_IDLE;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Status flags follow the state being entered so they can be registered
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      S_SCAN:  busy_nxt_s = 1'b1;
      S_DONE:  done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Status flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Working grid, row pointer and line counters; a cleared row is rescanned in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_r  <= {GW{1'b0}};
      row_r   <= RW'(ROWS-1);
      lines_r <= 5'd0;
      total_r <= 16'd0;
    end else if (accept_s) begin
      grid_r  <= bus.grid_in;
      row_r   <= RW'(ROWS-1);
      lines_r <= 5'd0;
    end else if (clear_s) begin
      grid_r  <= shifted_s;
      lines_r <= lines_r + 5'd1;
      if (total_r != 16'hFFFF) total_r <= total_r + 16'd1;
      else                     total_r <= total_r;
    end else if ((state_r == S_SCAN) && (row_r != {RW{1'b0}})) begin
      row_r <= row_r - {{(RW-1){1'b0}}, 1'b1};
    end else begin
      grid_r <= grid_r;
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.grid_out      = grid_r;
  assign bus.lines_cleared = lines_r;
  assign bus.total_lines   = total_r;

endmodule

// File: tb/tb_row_clear_engine.sv
// Directed bench for row_clear_engine: latency, compacted grid and line counters
// across single, multi and full clears, start held through a pass, and mid-pass reset.
module tb_row_clear_engine;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 3;
  localparam int GW   = ROWS * COLS * CW;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  row_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) bus ();

  row_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [GW-1:0] put(input logic [GW-1:0] g, input int r, input int c,
                                        input logic [CW-1:0] v);
    logic [GW-1:0] t;
    t = g;
    t[(r*COLS+c)*CW +: CW] = v;
    return t;
  endfunction

  function automatic logic [GW-1:0] fill_row(input logic [GW-1:0] g, input int r,
                                             input logic [CW-1:0] v);
    logic [GW-1:0] t;
    t = g;
    for (int c = 0; c < COLS; c++) t[(r*COLS+c)*CW +: CW] = v;
    return t;
  endfunction

  task automatic chk_g(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count clocks after the start edge until done is seen, bounded at 60
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.done && cyc < 60);
  endtask

  task automatic run_pass(input string tag, input logic [GW-1:0] gin, input int exp_lat,
                          input logic [GW-1:0] exp_g, input int exp_lines, input int exp_total);
    int cyc;
    bus.grid_in = gin;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk_i({tag, "_busy_hi"}, int'(bus.busy), 1);
    wait_done(cyc);
    chk_i({tag, "_latency"}, cyc, exp_lat);
    chk_g({tag, "_grid"}, bus.grid_out, exp_g);
    chk_i({tag, "_lines"}, int'(bus.lines_cleared), exp_lines);
    chk_i({tag, "_total"}, int'(bus.total_lines), exp_total);
    chk_i({tag, "_busy_lo"}, int'(bus.busy), 0);
    @(posedge clk);
    #1;
    chk_i({tag, "_done_pulse"}, int'(bus.done), 0);
    chk_g({tag, "_grid_hold"}, bus.grid_out, exp_g);
  endtask

  logic [GW-1:0] g;
  logic [GW-1:0] e;
  logic [GW-1:0] gall;
  int            cyc;
  bit            saw_done;

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.grid_in = '0;
    gall = '0;
    for (int r = 0; r < ROWS; r++) gall = fill_row(gall, r, 3'd6);

    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_busy", int'(bus.busy), 0);
    chk_i("rst_done", int'(bus.done), 0);
    chk_g("rst_grid", bus.grid_out, '0);
    chk_i("rst_lines", int'(bus.lines_cleared), 0);
    chk_i("rst_total", int'(bus.total_lines), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // empty grid: no clears, full 20-row scan
    run_pass("t1", '0, 20, '0, 0, 0);

    // bottom row full, one cell above drops into it
    g = fill_row('0, 19, 3'd1);
    g = put(g, 18, 0, 3'd5);
    e = put('0, 19, 0, 3'd5);
    run_pass("t2", g, 21, e, 1, 1);

    // four full rows under a single cell
    g = '0;
    for (int r = 16; r < 20; r++) g = fill_row(g, r, 3'(r - 15));
    g = put(g, 15, 0, 3'd7);
    e = put('0, 19, 0, 3'd7);
    run_pass("t3", g, 24, e, 4, 5);

    // every row full, including row 0
    run_pass("t4", gall, 40, '0, 20, 25);

    // start held through a pass with grid_in changed mid-pass
    g = fill_row('0, 10, 3'd2);
    g = put(g, 5, 3, 3'd2);
    e = put('0, 6, 3, 3'd2);
    bus.grid_in = g;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.grid_in = gall;
    wait_done(cyc);
    chk_i("t5_latency", cyc, 21);
    chk_g("t5_grid", bus.grid_out, e);
    chk_i("t5_lines", int'(bus.lines_cleared), 1);
    chk_i("t5_total", int'(bus.total_lines), 26);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk_i("t5_relaunch_done", int'(bus.done), 0);
    chk_i("t5_relaunch_busy", int'(bus.busy), 1);
    chk_g("t5_relaunch_grid", bus.grid_out, gall);
    chk_i("t5_relaunch_lines", int'(bus.lines_cleared), 0);
    wait_done(cyc);
    chk_i("t5b_latency", cyc, 40);
    chk_g("t5b_grid", bus.grid_out, '0);
    chk_i("t5b_lines", int'(bus.lines_cleared), 20);
    chk_i("t5b_total", int'(bus.total_lines), 46);
    @(posedge clk);
    #1;

    // reset five cycles into a pass
    bus.grid_in = gall;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_i("t6_busy", int'(bus.busy), 0);
    chk_i("t6_done", int'(bus.done), 0);
    chk_g("t6_grid", bus.grid_out, '0);
    chk_i("t6_lines", int'(bus.lines_cleared), 0);
    chk_i("t6_total", int'(bus.total_lines), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk_i("t6_no_done", int'(saw_done), 0);

    // engine restarts cleanly with counters from zero
    g = fill_row('0, 19, 3'd1);
    g = put(g, 18, 0, 3'd5);
    e = put('0, 19, 0, 3'd5);
    run_pass("t7", g, 21, e, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
